hack_boot_loader: RTL and testbench
===================================

// Module: hack_boot_loader
// PURPOSE
//   Boot sequencer for the Hack CPU. Holds the CPU in reset and receives a
//   program image over a valid/ready word stream. Writes the image into
//   instruction ROM from address 0, then verifies a checksum.
//   On a good checksum it releases the CPU so execution starts at PC=0.
// PARAMETERS
//   ADDR_W     15  instruction ROM address width (capacity 2**ADDR_W words)
//   DATA_W     16  instruction / stream word width
//   HOLD_CYC   4   cycles cpu_reset stays high after a good load (>=1)
// PORTS
//   clk        in   1       system clock, all state on rising edge
//   rst_n      in   1       asynchronous active-low reset
//   start      in   1       begin a new load (1-cycle pulse; level tolerated)
//   in_valid   in   1       stream word available
//   in_data    in   DATA_W  stream word
//   in_ready   out  1       loader accepts in_data this cycle
//   rom_we     out  1       instruction ROM write enable
//   rom_addr   out  ADDR_W  instruction ROM write address
//   rom_wdata  out  DATA_W  instruction ROM write data
//   cpu_reset  out  1       active-high reset to the CPU/PC
//   busy       out  1       load in progress (LEN/LOAD/CHECK/HOLD)
//   done       out  1       image loaded and verified, CPU running
//   error      out  1       last load failed (bad length or checksum)
// BEHAVIOUR
//   Reset: state=IDLE; cpu_reset=1, in_ready=0, rom_we=0, rom_addr=0,
//     busy=0, done=0, error=0; word count and checksum accumulator cleared.
//   Beat = in_valid & in_ready. Only beats advance state or are written.
//   Stream format: LEN word N, then N program words, then 1 checksum word.
//     The checksum equals the sum of the N program words mod 2**DATA_W.
//   FSM:
//   - IDLE: cpu_reset=1. start -> LEN.
//   - LEN: in_ready=1. On a beat, N=in_data. A value of N=0 or
//     N>2**ADDR_W goes to ERROR. Any other value clears count and sum and
//     goes to LOAD.
//   - LOAD: in_ready=1. On each beat, rom_we=1 in the same cycle
//     (combinational, 0 latency), with rom_addr=count and rom_wdata=in_data.
//     Also sum+=in_data and count+=1. The beat where count==N-1 goes to
//     CHECK. rom_we=0 on every non-beat cycle.
//   - CHECK: in_ready=1. On a beat, in_data==sum goes to HOLD, else ERROR.
//   - HOLD: in_ready=0, cpu_reset=1 for exactly HOLD_CYC cycles, then RUN.
//   - RUN: cpu_reset=0, done=1, in_ready=0. start -> LEN; cpu_reset=1 and
//     done=0 from the next cycle (live reload).
//   - ERROR: cpu_reset=1, error=1, in_ready=0. start -> LEN and clears
//     error.
//   - start is ignored in LEN/LOAD/CHECK/HOLD. A mid-load restart needs rst_n.
//   - cpu_reset is registered and is 1 in every state except RUN.
//   - in_ready, rom_we, rom_addr and rom_wdata are combinational from state,
//     count and in_valid/in_data.
//   - Width rules:
//     - count is ADDR_W+1 bits.
//     - Address N-1 = 2**ADDR_W-1 is the last ROM word; rom_addr never wraps.
//     - sum wraps mod 2**DATA_W.
//   - in_valid low stalls indefinitely in LEN/LOAD/CHECK with no timeout.
//   - rst_n low at any time aborts the load immediately (async). All
//     outputs return to reset values and ROM contents are left as they are.
// TESTING
//   1. N=3, words 0x0002,0xEC10,0x0000, chk 0xEC12 -> rom_we on 3 beats at
//      addr 0,1,2; HOLD 4 cycles; cpu_reset falls, done=1, error=0.
//   2. Same image, chk 0xEC13 -> ERROR, error=1, cpu_reset stays 1, done=0.
//      Then start -> LEN and error=0.
//   3. LEN=0 and separately LEN=0x8001 (ADDR_W=15) -> ERROR after 1 beat,
//      no rom_we, in_ready=0.
//   4. Random in_valid gaps (50%) with N=8 -> writes only on beats, addr
//      0..7 in order, identical ROM image to the gap-free run.
//   5. rst_n asserted mid-LOAD at count=2 -> outputs at reset values
//      asynchronously. After release: IDLE, and in_ready=0 until start.
//   6. In RUN pulse start, then load N=1 word 0x7FFF with chk 0x7FFF ->
//      cpu_reset high the next cycle, then re-released; done=1.

Source files
------------

// File: rtl/hack_boot_loader_if.sv
// Stream and instruction-ROM write bus between an image source and the Hack boot loader.
interface hack_boot_loader_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              rom_we;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, rom_we, rom_addr, rom_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, rom_we, rom_addr, rom_wdata
  );
endinterface

// File: rtl/hack_boot_loader.sv
// Boot sequencer for the Hack CPU: streams a length-prefixed image into instruction ROM,
// verifies its additive checksum and only then releases the CPU reset.
module hack_boot_loader #(
  parameter int ADDR_W   = 15,
  parameter int DATA_W   = 16,
  parameter int HOLD_CYC = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  hack_boot_loader_if.slave bus,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int          CNT_W  = ADDR_W + 1;
  localparam int          HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam int unsigned MAX_N  = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    LOAD,
    CHECK,
    HOLD,
    RUN,
    ERROR
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  n_last_q;
  logic [DATA_W-1:0] sum_q;
  logic [HOLD_W-1:0] hold_q;
  logic              cpu_reset_q;

  logic              accepting;
  logic              beat;
  logic              len_bad;
  logic              load_last;
  logic              hold_last;
  logic [31:0]       len_wide;

  assign accepting = (state_q == LEN) || (state_q == LOAD) || (state_q == CHECK);
  assign beat      = bus.in_valid && accepting;
  assign len_wide  = 32'(bus.in_data);
  // N must address at least one word and no more than the full ROM.
  assign len_bad   = (len_wide == 32'd0) || (len_wide > MAX_N);
  assign load_last = (count_q == n_last_q);
  assign hold_last = (hold_q == HOLD_W'(HOLD_CYC - 1));

  assign bus.in_ready  = accepting;
  assign bus.rom_we    = (state_q == LOAD) && beat;
  assign bus.rom_addr  = count_q[ADDR_W-1:0];
  assign bus.rom_wdata = bus.in_data;

  assign cpu_reset = cpu_reset_q;
  assign busy      = (state_q == LEN) || (state_q == LOAD) ||
                     (state_q == CHECK) || (state_q == HOLD);
  assign done      = (state_q == RUN);
  assign error     = (state_q == ERROR);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = LEN;
      LEN:   if (beat) state_d = len_bad ? ERROR : LOAD;
      LOAD:  if (beat && load_last) state_d = CHECK;
      CHECK: if (beat) state_d = (bus.in_data == sum_q) ? HOLD : ERROR;
      HOLD:  if (hold_last) state_d = RUN;
      RUN:   if (start) state_d = LEN;
      ERROR: if (start) state_d = LEN;
      default: state_d = IDLE;
    endcase
  end

  // cpu_reset is registered from the next state so it drops exactly on entry to RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cpu_reset_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cpu_reset_q <= (state_d != RUN);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      n_last_q <= '0;
      sum_q    <= '0;
      hold_q   <= '0;
    end else begin
      case (state_q)
        LEN: begin
          if (beat && !len_bad) begin
            n_last_q <= CNT_W'(bus.in_data) - CNT_W'(1);
            count_q  <= '0;
            sum_q    <= '0;
          end
        end
        LOAD: begin
          if (beat) begin
            count_q <= count_q + CNT_W'(1);
            sum_q   <= sum_q + bus.in_data;
          end
        end
        CHECK: begin
          if (beat) hold_q <= '0;
        end
        HOLD: begin
          if (!hold_last) hold_q <= hold_q + HOLD_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hack_boot_loader.sv
// Scoreboard bench for hack_boot_loader: expected ROM writes are queued by the stimulus
// and popped by a monitor; status outputs are checked at hand-computed cycle points.
module tb_hack_boot_loader;

  localparam int ADDR_W   = 15;
  localparam int DATA_W   = 16;
  localparam int HOLD_CYC = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic cpu_reset, busy, done, error;

  int   total = 0;
  int   bad = 0;
  wr_t  exp_q[$];
  wr_t  mon_w;

  logic [15:0] img1 [8] = '{16'h0002, 16'hEC10, 16'h0000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
  logic [15:0] img4 [8] = '{16'h1000, 16'h2000, 16'h3000, 16'h4000,
                            16'h5000, 16'h6000, 16'h7000, 16'h8000};
  logic [15:0] img6 [8] = '{16'h7FFF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};

  hack_boot_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  hack_boot_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .HOLD_CYC(HOLD_CYC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bus       (bus),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkStatus(input string tag, input bit cr, input bit ir, input bit bz,
                             input bit dn, input bit er);
    checkOutput({tag, "/cpu_reset"}, 32'(cpu_reset), 32'(cr));
    checkOutput({tag, "/in_ready"}, 32'(bus.in_ready), 32'(ir));
    checkOutput({tag, "/busy"}, 32'(busy), 32'(bz));
    checkOutput({tag, "/done"}, 32'(done), 32'(dn));
    checkOutput({tag, "/error"}, 32'(error), 32'(er));
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    nextCycle();
    start = 1'b0;
  endtask

  // Holds a word on the stream until the loader takes it; the beat is the next rising edge.
  task automatic sendWord(input logic [15:0] w, input bit gaps);
    int waited = 0;
    if (gaps) repeat ($urandom_range(0, 2)) nextCycle();
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      waited++;
      if (waited > 50) begin
        total++;
        bad++;
        $display("[TB] FAIL send_timeout: got in_ready=0 for 50 cycles, expected 1");
        break;
      end
    end
    nextCycle();
    bus.in_valid = 1'b0;
  endtask

  task automatic applyStimulus(input logic [15:0] len, input logic [15:0] words [8],
                               input int n, input logic [15:0] chk, input bit gaps);
    sendWord(len, gaps);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({ADDR_W'(i), words[i]});
      sendWord(words[i], gaps);
    end
    sendWord(chk, gaps);
  endtask

  // Every ROM write must match the head of the expected-write queue.
  always @(negedge clk) begin
    if (bus.rom_we) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                 bus.rom_addr, bus.rom_wdata);
      end else begin
        mon_w = exp_q.pop_front();
        checkOutput("rom_addr", 32'(bus.rom_addr), 32'(mon_w.addr));
        checkOutput("rom_wdata", 32'(bus.rom_wdata), 32'(mon_w.data));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) nextCycle();
    rst_n = 1'b1;

    @(negedge clk);
    checkStatus("reset", 1, 0, 0, 0, 0);
    checkOutput("reset/rom_we", 32'(bus.rom_we), 32'd0);
    checkOutput("reset/rom_addr", 32'(bus.rom_addr), 32'd0);
    nextCycle();

    $display("[TB] good load, N=3");
    pulseStart();
    applyStimulus(16'd3, img1, 3, 16'hEC12, 1'b0);
    for (int i = 0; i < HOLD_CYC; i++) begin
      @(negedge clk);
      checkStatus("hold", 1, 0, 1, 0, 0);
      nextCycle();
    end
    @(negedge clk);
    checkStatus("run1", 0, 0, 0, 1, 0);
    nextCycle();

    $display("[TB] bad checksum");
    pulseStart();
    applyStimulus(16'd3, img1, 3, 16'hEC13, 1'b0);
    @(negedge clk);
    checkStatus("badchk", 1, 0, 0, 0, 1);
    nextCycle();
    pulseStart();
    @(negedge clk);
    checkStatus("restart", 1, 1, 1, 0, 0);
    nextCycle();

    $display("[TB] bad lengths");
    sendWord(16'h0000, 1'b0);
    @(negedge clk);
    checkStatus("len0", 1, 0, 0, 0, 1);
    nextCycle();
    pulseStart();
    sendWord(16'h8001, 1'b0);
    @(negedge clk);
    checkStatus("len8001", 1, 0, 0, 0, 1);
    nextCycle();

    $display("[TB] N=8 with stream gaps");
    pulseStart();
    applyStimulus(16'd8, img4, 8, 16'h4000, 1'b1);
    repeat (HOLD_CYC - 1) nextCycle();
    @(negedge clk);
    checkStatus("hold4", 1, 0, 1, 0, 0);
    nextCycle();
    @(negedge clk);
    checkStatus("run4", 0, 0, 0, 1, 0);
    nextCycle();

    $display("[TB] full-size length then async reset mid-load");
    pulseStart();
    sendWord(16'h8000, 1'b0);
    @(negedge clk);
    checkStatus("len8000", 1, 1, 1, 0, 0);
    nextCycle();
    exp_q.push_back({ADDR_W'(0), 16'h1234});
    sendWord(16'h1234, 1'b0);
    exp_q.push_back({ADDR_W'(1), 16'h5678});
    sendWord(16'h5678, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h9ABC;
    #1 rst_n = 1'b0;
    #1;
    checkStatus("async_rst", 1, 0, 0, 0, 0);
    checkOutput("async_rst/rom_we", 32'(bus.rom_we), 32'd0);
    checkOutput("async_rst/rom_addr", 32'(bus.rom_addr), 32'd0);
    nextCycle();
    nextCycle();
    rst_n = 1'b1;
    @(negedge clk);
    checkStatus("post_rst", 1, 0, 0, 0, 0);
    checkOutput("post_rst/rom_we", 32'(bus.rom_we), 32'd0);
    nextCycle();
    bus.in_valid = 1'b0;

    $display("[TB] live reload from RUN");
    pulseStart();
    applyStimulus(16'd3, img1, 3, 16'hEC12, 1'b0);
    repeat (HOLD_CYC) nextCycle();
    @(negedge clk);
    checkStatus("run6a", 0, 0, 0, 1, 0);
    nextCycle();
    pulseStart();
    @(negedge clk);
    checkStatus("reload", 1, 1, 1, 0, 0);
    nextCycle();
    applyStimulus(16'd1, img6, 1, 16'h7FFF, 1'b0);
    repeat (HOLD_CYC) nextCycle();
    @(negedge clk);
    checkStatus("run6b", 0, 0, 0, 1, 0);
    nextCycle();

    checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
